// File: rtl/option23_pkg.sv
// Shared constants, FSM encoding and window arithmetic for the option23 loader.
// Combinational helpers only; no latency or backpressure of its own.
package option23_pkg;

    localparam int WORD_COUNT = 22;
    localparam int ADDR_W     = 5;

    typedef enum logic [1:0] {IDLE, WAIT, XFER, RESP} state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              err;
    } req_t;

    function automatic logic [ADDR_W-1:0] next_win(input logic [ADDR_W-1:0] w);
        return (w == ADDR_W'(WORD_COUNT - 1)) ? '0 : w + 1'b1;
    endfunction

endpackage

// File: rtl/option23_slot_tracker.sv
// Mirrors the memory's 3-bit bit phase and its mod-WORD_COUNT word window.
// Free-running from reset; no backpressure.
module option23_slot_tracker
    import option23_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic [2:0]        phase,
    output logic [ADDR_W-1:0] win,
    output logic              win_start
);

    logic [2:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] win_q, win_d;

    always_comb begin
        phase_d = phase_q + 3'd1;
        win_d   = (phase_q == 3'd7) ? next_win(win_q) : win_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            win_q   <= '0;
        end else begin
            phase_q <= phase_d;
            win_q   <= win_d;
        end
    end

    assign phase     = phase_q;
    assign win       = win_q;
    assign win_start = (phase_q == 3'd0);

endmodule

// File: rtl/option23_loader.sv
// Byte read/write front-end serialising requests into the option23 rotating memory.
// Latency up to 8*WORD_COUNT+9 cycles; one request in flight, req_ready low while busy.
module option23_loader
    import option23_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_data,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [7:0]        rsp_data,
    output logic              mem_write,
    output logic              mem_din,
    input  logic [7:0]        mem_dout
);

    logic [2:0]        phase;
    logic [ADDR_W-1:0] win;
    logic              win_start;

    option23_slot_tracker u_slot (
        .clk       (clk),
        .reset     (reset),
        .phase     (phase),
        .win       (win),
        .win_start (win_start)
    );

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_din_q, mem_din_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  rsp_data_q, rsp_data_d;

    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_data;
    logic              hit;
    logic [2:0]        nxt_phase;

    // A hit is the last cycle before the target window boundary: window A for
    // writes (serial outputs are registered), window A+1 for reads (capture).
    always_comb begin
        sel_write = (state_q == IDLE) ? req_write : req_q.write;
        sel_addr  = (state_q == IDLE) ? req_addr  : req_q.addr;
        sel_data  = (state_q == IDLE) ? req_data  : req_q.data;
        nxt_phase = phase + 3'd1;
        hit       = (phase == 3'd7) &&
                    (sel_write ? (next_win(win) == sel_addr) : (win == sel_addr));
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        mem_write_d = 1'b0;
        mem_din_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = '{write: req_write, addr: req_addr, data: req_data, err: 1'b0};
                    if (req_addr >= ADDR_W'(WORD_COUNT)) begin
                        req_d.err   = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end else if (hit) begin
                        state_d     = sel_write ? XFER : RESP;
                        mem_write_d = sel_write;
                        mem_din_d   = sel_write & sel_data[0];
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (hit) begin
                    state_d     = sel_write ? XFER : RESP;
                    mem_write_d = sel_write;
                    mem_din_d   = sel_write & sel_data[0];
                end
            end
            XFER: begin
                if (phase != 3'd7) begin
                    mem_write_d = 1'b1;
                    mem_din_d   = req_q.data[nxt_phase];
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (req_q.err) begin
                    state_d = IDLE;
                end else if (win_start) begin
                    rsp_valid_d = 1'b1;
                    if (!req_q.write) begin
                        rsp_data_d = mem_dout;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            mem_write_q <= 1'b0;
            mem_din_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            mem_write_q <= mem_write_d;
            mem_din_q   <= mem_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign mem_write = mem_write_q;
    assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_option23_loader.sv
// Directed bench: option23_loader against a behavioural rotating word memory.
module tb_option23_loader;
    import option23_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [7:0]        req_data = '0;
    logic              rsp_valid;
    logic              rsp_err;
    logic [7:0]        rsp_data;
    logic              mem_write;
    logic              mem_din;
    logic [7:0]        mem_dout;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;

    option23_loader dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .mem_write (mem_write),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    // Memory model: word w takes serial bits during window w and is presented
    // on dout throughout window w+1.
    logic [7:0]        mem [WORD_COUNT];
    logic [2:0]        m_phase = '0;
    logic [ADDR_W-1:0] m_win = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_phase <= '0;
            m_win   <= '0;
        end else begin
            if (mem_write) mem[m_win][m_phase] <= mem_din;
            m_phase <= m_phase + 3'd1;
            if (m_phase == 3'd7) m_win <= (m_win == ADDR_W'(WORD_COUNT - 1)) ? '0 : m_win + 1'b1;
        end
    end

    assign mem_dout = mem[(m_win == '0) ? WORD_COUNT - 1 : int'(m_win) - 1];

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns the cycle whose closing edge accepted the request.
    task automatic issue(input logic wr, input int a, input int d, output int acc);
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk("ready timeout", 0, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = ADDR_W'(a);
        req_data  = 8'(d);
        acc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_to_rsp(input int budget, output int r_cyc, output int r_win,
                              output int r_ph, output int w_first, output int w_cnt,
                              output int w_win, output logic [7:0] w_byte);
        r_cyc = -1; r_win = -1; r_ph = -1;
        w_first = -1; w_cnt = 0; w_win = -1; w_byte = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mem_write) begin
                if (w_first < 0) begin
                    w_first = cyc;
                    w_win   = int'(m_win);
                end
                w_cnt++;
                w_byte[m_phase] = mem_din;
            end
            if (rsp_valid) begin
                r_cyc = cyc;
                r_win = int'(m_win);
                r_ph  = int'(m_phase);
                break;
            end
        end
        if (r_cyc < 0) chk("rsp timeout", 0, 1);
    endtask

    task automatic wait_slot(input int ph, input int w);
        for (int i = 0; i < 400 && !(int'(m_phase) == ph && int'(m_win) == w); i++)
            @(negedge clk);
        if (!(int'(m_phase) == ph && int'(m_win) == w)) chk("slot timeout", 0, 1);
    endtask

    initial begin
        int acc, rc, rw, rp, wf, wc, ww, pulses, writes;
        logic [7:0] wb;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", int'(req_ready), 1);
        chk("rst mem_write", int'(mem_write), 0);
        chk("rst mem_din", int'(mem_din), 0);
        chk("rst rsp_valid", int'(rsp_valid), 0);
        chk("rst rsp_err", int'(rsp_err), 0);
        chk("rst rsp_data", int'(rsp_data), 0);
        reset = 1'b0;

        // Accepted at phase 0 of window 0: misses it, transfers next revolution.
        issue(1'b1, 0, 'hA5, acc);
        run_to_rsp(400, rc, rw, rp, wf, wc, ww, wb);
        chk("t1 write window", ww, 0);
        chk("t1 write cycles", wc, 8);
        chk("t1 din byte", int'(wb), 'hA5);
        chk("t1 rsp offset", rc - wf, 9);
        chk("t1 worst latency", rc - acc, 8 * WORD_COUNT + 9);
        chk("t1 rsp_err", int'(rsp_err), 0);

        issue(1'b1, 5, 'h3C, acc);
        run_to_rsp(400, rc, rw, rp, wf, wc, ww, wb);
        chk("t2 write window", ww, 5);
        chk("t2 write byte", int'(wb), 'h3C);
        issue(1'b0, 5, 0, acc);
        run_to_rsp(400, rc, rw, rp, wf, wc, ww, wb);
        chk("t2 read data", int'(rsp_data), 'h3C);
        chk("t2 read err", int'(rsp_err), 0);
        chk("t2 rsp window", rw, 6);
        chk("t2 rsp phase", rp, 1);
        chk("t2 read no write", wc, 0);

        issue(1'b1, 21, 'hFF, acc);
        run_to_rsp(400, rc, rw, rp, wf, wc, ww, wb);
        chk("t3 write window", ww, 21);
        chk("t3 write rsp window", rw, 0);
        issue(1'b0, 21, 0, acc);
        run_to_rsp(400, rc, rw, rp, wf, wc, ww, wb);
        chk("t3 read data", int'(rsp_data), 'hFF);
        chk("t3 rsp window", rw, 0);
        chk("t3 rsp phase", rp, 1);

        issue(1'b0, 22, 0, acc);
        run_to_rsp(20, rc, rw, rp, wf, wc, ww, wb);
        chk("t4 rd err latency", rc - acc, 1);
        chk("t4 rd err flag", int'(rsp_err), 1);
        chk("t4 rsp_data held", int'(rsp_data), 'hFF);
        issue(1'b1, 31, 'h12, acc);
        run_to_rsp(20, rc, rw, rp, wf, wc, ww, wb);
        chk("t4 wr err latency", rc - acc, 1);
        chk("t4 wr err flag", int'(rsp_err), 1);
        chk("t4 no mem_write", wc, 0);

        // Accepted at phase 2 of window 3: next window-3 start is 174 cycles on,
        // response lands at phase 1 of window 4 after that.
        wait_slot(2, 3);
        issue(1'b1, 3, 'h5A, acc);
        run_to_rsp(400, rc, rw, rp, wf, wc, ww, wb);
        chk("t5 xfer start", wf - acc, 174);
        chk("t5 rsp latency", rc - acc, 183);
        chk("t5 write byte", int'(wb), 'h5A);

        // Accepted on the last cycle before window 9: transfer starts immediately.
        wait_slot(7, 8);
        issue(1'b1, 9, 'hC3, acc);
        run_to_rsp(400, rc, rw, rp, wf, wc, ww, wb);
        chk("t5b xfer start", wf - acc, 1);
        chk("t5b rsp latency", rc - acc, 10);
        issue(1'b0, 9, 0, acc);
        run_to_rsp(400, rc, rw, rp, wf, wc, ww, wb);
        chk("t5b raw data", int'(rsp_data), 'hC3);

        issue(1'b1, 12, 'h77, acc);
        for (int i = 0; i < 400 && !mem_write; i++) @(negedge clk);
        chk("t6 xfer seen", int'(mem_write), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6 mem_write", int'(mem_write), 0);
        chk("t6 req_ready", int'(req_ready), 1);
        chk("t6 rsp_valid", int'(rsp_valid), 0);
        reset = 1'b0;
        pulses = 0;
        writes = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
            if (mem_write) writes++;
        end
        chk("t6 dropped rsp", pulses, 0);
        chk("t6 dropped writes", writes, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
